seq_mult_datapath: RTL

Shift-and-add datapath for the 8-step sequential multiplier. It sits directly downstream of the multiplier control unit and consumes that unit's one_shot, first and ready strobes. It latches operands, performs one partial-product step per cycle for WIDTH cycles, and presents a registered product with a valid flag and a sequencing-error flag.

---
 rtl/seq_mult_datapath.sv | 104 ++++++++++
 1 files changed

// File: rtl/seq_mult_datapath.sv
// Shift-and-add datapath for the sequential multiplier: latches operands on
// one_shot, accumulates one partial product per cycle, registers the result on ready.
module seq_mult_datapath #(
   parameter int unsigned WIDTH  = 8,
   parameter bit          SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               one_shot,
   input  logic               first,
   input  logic               ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               product_valid,
   output logic               seq_error
);

   localparam int unsigned    CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_DONE = CW'(WIDTH);

   logic [2*WIDTH-1:0] a_reg;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   b_reg;
   logic [CW-1:0]      cnt;
   logic               loaded;
   logic               sign;

   logic               do_step;
   logic               do_latch;
   logic               err_now;

   // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      if (SIGNED && v[WIDTH-1]) begin
         return -v;
      end
      return v;
   endfunction

   always_comb begin
      do_step  = 1'b0;
      do_latch = 1'b0;
      err_now  = 1'b0;
      if (!one_shot) begin
         do_step  = loaded && ((first && (cnt == '0)) ||
                               ((cnt != '0) && (cnt < CNT_DONE)));
         do_latch = ready && !product_valid && (cnt == CNT_DONE);
      end
      if (first && (!loaded || (cnt != '0))) begin
         err_now = 1'b1;
      end
      if (ready && loaded && (cnt != CNT_DONE)) begin
         err_now = 1'b1;
      end
      if (one_shot && first) begin
         err_now = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg         <= '0;
         b_reg         <= '0;
         acc           <= '0;
         cnt           <= '0;
         loaded        <= 1'b0;
         sign          <= 1'b0;
         product       <= '0;
         product_valid <= 1'b0;
         seq_error     <= 1'b0;
      end else begin
         if (err_now) begin
            seq_error <= 1'b1;
         end
         if (one_shot) begin
            a_reg         <= {{WIDTH{1'b0}}, magnitude(multiplicand)};
            b_reg         <= magnitude(multiplier);
            acc           <= '0;
            cnt           <= '0;
            loaded        <= 1'b1;
            sign          <= SIGNED ? (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]) : 1'b0;
            product_valid <= 1'b0;
         end else begin
            if (do_step) begin
               if (b_reg[0]) begin
                  acc <= acc + a_reg;
               end
               a_reg <= a_reg << 1;
               b_reg <= b_reg >> 1;
               cnt   <= cnt + 1'b1;
            end
            if (do_latch) begin
               product       <= sign ? -acc : acc;
               product_valid <= 1'b1;
               loaded        <= 1'b0;
            end else if (!ready) begin
               product_valid <= 1'b0;
            end
         end
      end
   end

endmodule
